// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM-stage initiator and the data memory.
// One request at a time with a req/ack handshake.
interface mem_access_unit_if;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [63:0] dbus_addr_o;
   logic [63:0] dbus_wdata_o;
   logic [7:0]  dbus_be_o;
   logic        dbus_ack_i;
   logic [63:0] dbus_rdata_i;

   modport master (
      output dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_be_o,
      input  dbus_ack_i, dbus_rdata_i
   );

   modport slave (
      input  dbus_req_o, dbus_we_o, dbus_addr_o, dbus_wdata_o, dbus_be_o,
      output dbus_ack_i, dbus_rdata_i
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: one bus transaction at a time, load
// alignment/extension, and pipeline stall while a transaction is in flight.
module mem_access_unit (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [63:0]             result_i,
   input  logic [4:0]              reg_write_addr_i,
   input  logic                    reg_write_enable_i,
   input  logic                    mem_valid_i,
   input  logic                    mem_rw_i,
   input  logic                    mem_load_signed_i,
   input  logic [63:0]             mem_data_i,
   input  logic [7:0]              mem_data_byte_valid_i,
   mem_access_unit_if.master       dbus,
   output logic [63:0]             wb_data_o,
   output logic [4:0]              wb_addr_o,
   output logic                    wb_we_o,
   output logic                    stall_req_o,
   output logic                    misalign_o
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state_q, state_d;
   logic        req_q, we_q;
   logic [7:0]  be_q;
   logic [63:0] addr_q, wdata_q, rbuf_q;
   logic        legal;
   logic [63:0] shifted, load_val;

   // Mask must be a naturally aligned 1/2/4/8-byte group starting at the address offset.
   function automatic logic mask_legal(input logic [7:0] m, input logic [2:0] off);
      logic       shape;
      logic [2:0] lo;
      case (m)
         8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
         8'h03, 8'h0C, 8'h30, 8'hC0, 8'h0F, 8'hF0, 8'hFF: shape = 1'b1;
         default:                                          shape = 1'b0;
      endcase
      lo = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) lo = i[2:0];
      return shape && (lo == off);
   endfunction

   assign legal   = mask_legal(mem_data_byte_valid_i, result_i[2:0]);
   assign shifted = rbuf_q >> {result_i[2:0], 3'b000};

   always_comb begin
      load_val = shifted;
      case ($countones(be_q))
         1:       load_val = {{56{mem_load_signed_i & shifted[7]}},  shifted[7:0]};
         2:       load_val = {{48{mem_load_signed_i & shifted[15]}}, shifted[15:0]};
         4:       load_val = {{32{mem_load_signed_i & shifted[31]}}, shifted[31:0]};
         default: load_val = shifted;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      stall_req_o = 1'b0;
      misalign_o  = 1'b0;
      wb_we_o     = reg_write_enable_i;
      wb_data_o   = result_i;
      case (state_q)
         IDLE: if (mem_valid_i) begin
            wb_we_o = 1'b0;
            if (legal) begin
               stall_req_o = 1'b1;
               state_d     = BUSY;
            end else begin
               misalign_o = 1'b1;
            end
         end
         BUSY: begin
            stall_req_o = 1'b1;
            wb_we_o     = 1'b0;
            if (dbus.dbus_ack_i) state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
            wb_we_o = reg_write_enable_i & ~we_q;
            if (!we_q) wb_data_o = load_val;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 8'h00;
         addr_q  <= 64'h0;
         wdata_q <= 64'h0;
         rbuf_q  <= 64'h0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && mem_valid_i && legal) begin
            req_q   <= 1'b1;
            we_q    <= mem_rw_i;
            be_q    <= mem_data_byte_valid_i;
            wdata_q <= mem_data_i;
            addr_q  <= {result_i[63:3], 3'b000};
         end
         if (state_q == BUSY && dbus.dbus_ack_i) begin
            req_q  <= 1'b0;
            rbuf_q <= dbus.dbus_rdata_i;
         end
      end
   end

   assign dbus.dbus_req_o   = req_q;
   assign dbus.dbus_we_o    = we_q;
   assign dbus.dbus_be_o    = be_q;
   assign dbus.dbus_addr_o  = addr_q;
   assign dbus.dbus_wdata_o = wdata_q;
   assign wb_addr_o         = reg_write_addr_i;

endmodule
